// File: rtl/dist_pkg.sv
// dist_pkg: shared state type, default parameters and bin classification for dist_histogram
package dist_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DUMP} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_MIN_NUM = 256;
  localparam int DEF_BIN_SHIFT = 5;
  localparam int DEF_BIN_NUM = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_SAMPLE_NUM = 1024;
  // Returns 0..bin_num-1 for in-range samples, bin_num for underflow, bin_num+1 for overflow
  function automatic int bin_index(input logic [31:0] data, input logic [31:0] min_num,
                                   input int shift, input int bin_num);
    logic [32:0] off;
    off = {1'b0, data} - {1'b0, min_num};
    return off[32] ? bin_num : (off >> shift) >= 33'(bin_num) ? bin_num + 1 : int'(off >> shift);
  endfunction
endpackage

// File: rtl/hist_bin_cnt.sv
// hist_bin_cnt: one saturating histogram bin counter with synchronous clear
module hist_bin_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dist_histogram.sv
// dist_histogram: collects SAMPLE_NUM samples into a histogram with min/max/sum, then streams the bins out
module dist_histogram
  import dist_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MIN_NUM = DEF_MIN_NUM,
  parameter int BIN_SHIFT = DEF_BIN_SHIFT,
  parameter int BIN_NUM = DEF_BIN_NUM,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SAMPLE_NUM = DEF_SAMPLE_NUM,
  localparam int IDX_W = $clog2(BIN_NUM + 2),
  localparam int SUM_W = DATA_W + $clog2(SAMPLE_NUM) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [CNT_W-1:0]  out_cnt,
  output logic [DATA_W-1:0] stat_min,
  output logic [DATA_W-1:0] stat_max,
  output logic [SUM_W-1:0]  stat_sum,
  output logic              busy,
  output logic              done
);
  localparam int NB = BIN_NUM + 2;
  localparam int SC_W = $clog2(SAMPLE_NUM + 1);
  state_t state;
  logic [SC_W-1:0] smp_cnt;
  logic [CNT_W-1:0] cnts [NB];
  logic accept, clr;
  int code;
  assign in_ready = state == COLLECT;
  assign out_valid = state == DUMP;
  assign busy = state != IDLE;
  assign accept = in_valid && in_ready;
  assign clr = state == IDLE && start;
  assign code = bin_index(32'(in_data), 32'(MIN_NUM), BIN_SHIFT, BIN_NUM);
  // Bins are frozen during DUMP, so the indexed read is stable under back-pressure
  assign out_cnt = cnts[out_idx];
  for (genvar g = 0; g < NB; g++) begin : g_bin
    hist_bin_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .inc(accept && code == g),
      .cnt(cnts[g])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      smp_cnt <= '0;
      stat_min <= '1;
      stat_max <= '0;
      stat_sum <= '0;
      out_idx <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= COLLECT;
          smp_cnt <= '0;
          stat_min <= '1;
          stat_max <= '0;
          stat_sum <= '0;
          out_idx <= '0;
        end
        COLLECT: if (accept) begin
          smp_cnt <= smp_cnt + 1'b1;
          if (in_data < stat_min) stat_min <= in_data;
          if (in_data > stat_max) stat_max <= in_data;
          stat_sum <= stat_sum + SUM_W'(in_data);
          if (smp_cnt == SC_W'(SAMPLE_NUM - 1)) state <= DUMP;
        end
        DUMP: if (out_ready) begin
          out_idx <= out_idx == IDX_W'(NB - 1) ? '0 : out_idx + 1'b1;
          if (out_idx == IDX_W'(NB - 1)) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dist_histogram.sv
// tb_dist_histogram: scoreboard bench for dist_histogram at defaults, SAMPLE_NUM=6 and CNT_W=4
`timescale 1ns/1ps
module tb_dist_histogram;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, done_cnt = 0;
  int exp_q[$];

  logic d_start = 0, d_in_valid = 0, d_out_ready = 0;
  logic [15:0] d_in_data = 0;
  logic d_in_ready, d_out_valid, d_busy, d_done;
  logic [3:0] d_out_idx;
  logic [15:0] d_out_cnt, d_min, d_max;
  logic [26:0] d_sum;

  logic b_start = 0, b_in_valid = 0, b_out_ready = 0;
  logic [15:0] b_in_data = 0;
  logic b_in_ready, b_out_valid, b_busy, b_done;
  logic [3:0] b_out_idx;
  logic [15:0] b_out_cnt, b_min, b_max;
  logic [19:0] b_sum;

  logic s_start = 0, s_in_valid = 0, s_out_ready = 0;
  logic [15:0] s_in_data = 0;
  logic s_in_ready, s_out_valid, s_busy, s_done;
  logic [3:0] s_out_idx, s_out_cnt;
  logic [15:0] s_min, s_max;
  logic [21:0] s_sum;

  dist_histogram u_def (
    .clk(clk), .rst(rst), .start(d_start), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_idx(d_out_idx),
    .out_cnt(d_out_cnt), .stat_min(d_min), .stat_max(d_max), .stat_sum(d_sum), .busy(d_busy), .done(d_done));

  dist_histogram #(.SAMPLE_NUM(6)) u_bnd (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
    .out_cnt(b_out_cnt), .stat_min(b_min), .stat_max(b_max), .stat_sum(b_sum), .busy(b_busy), .done(b_done));

  dist_histogram #(.CNT_W(4), .SAMPLE_NUM(20)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_idx(s_out_idx),
    .out_cnt(s_out_cnt), .stat_min(s_min), .stat_max(s_max), .stat_sum(s_sum), .busy(s_busy), .done(s_done));

  always @(posedge clk) if (d_done) done_cnt++;

  task automatic test_reset();
    int dc;
    #2 rst = 1;
    #1;
    n_chk++;
    if ({d_in_ready, d_out_valid, d_busy, d_done} !== 4'b0 || d_min !== 16'hFFFF || d_max !== 0 || d_sum !== 0 || d_out_idx !== 0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b done=%b min=%h max=%h sum=%0d idx=%0d, required 0 0 0 0 ffff 0 0 0",
               d_in_ready, d_out_valid, d_busy, d_done, d_min, d_max, d_sum, d_out_idx);
    end
    @(negedge clk) rst = 0;
    d_start = 1;
    @(negedge clk) d_start = 0;
    for (int i = 0; i < 10; i++) begin
      d_in_valid = 1;
      d_in_data = 16'(400 + i);
      @(negedge clk);
    end
    d_in_valid = 0;
    n_chk++;
    if (d_sum !== 27'd4045 || d_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_collect: sum=%0d busy=%b, required 4045 1", d_sum, d_busy);
    end
    dc = done_cnt;
    rst = 1;
    #1;
    n_chk++;
    if (d_in_ready !== 0 || d_busy !== 0 || d_min !== 16'hFFFF || d_sum !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: rdy=%b busy=%b min=%h sum=%0d, required 0 0 ffff 0", d_in_ready, d_busy, d_min, d_sum);
    end
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      if (u_def.cnts[k] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_bin%0d: got %0d, required 0", k, u_def.cnts[k]);
      end
    end
    @(negedge clk) rst = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (done_cnt !== dc) begin
      n_fail++;
      $display("FAIL reset_no_done: done pulses %0d, required %0d", done_cnt, dc);
    end
  endtask

  task automatic run_default(input bit rnd, input bit gaps, input bit stalls, input bit poke);
    int mb[10];
    int mn = 65535, mx = 0, sum = 0, acc = 0, cyc = 0, k = 0, dc, code;
    logic [15:0] v;
    dc = done_cnt;
    d_start = 1;
    @(negedge clk) d_start = 0;
    while (acc < 1024 && cyc < 8000) begin
      v = rnd ? 16'($urandom_range(511, 256)) : 16'd300;
      d_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      d_in_data = v;
      d_start = poke && $urandom_range(0, 7) == 0;
      if (d_in_valid && d_in_ready) begin
        code = v < 256 ? 8 : ((int'(v) - 256) >> 5) >= 8 ? 9 : (int'(v) - 256) >> 5;
        mb[code]++;
        if (v < mn) mn = v;
        if (v > mx) mx = v;
        sum += v;
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    d_in_valid = 0;
    d_start = 0;
    n_chk++;
    if (acc < 1024) begin
      n_fail++;
      $display("FAIL collect_timeout: accepted %0d, required 1024", acc);
    end
    n_chk++;
    if (d_in_ready !== 0 || d_out_valid !== 1 || d_min !== 16'(mn) || d_max !== 16'(mx) || d_sum !== 27'(sum)) begin
      n_fail++;
      $display("FAIL stats: rdy=%b vld=%b min=%0d max=%0d sum=%0d, required 0 1 %0d %0d %0d",
               d_in_ready, d_out_valid, d_min, d_max, d_sum, mn, mx, sum);
    end
    for (int i = 0; i < 10; i++) exp_q.push_back(mb[i]);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 8000) begin
      d_out_ready = stalls ? ($urandom_range(0, 1) == 1) : 1'b1;
      d_start = poke && $urandom_range(0, 3) == 0;
      n_chk++;
      if (d_out_valid !== 1 || d_out_idx !== 4'(k) || d_out_cnt !== 16'(exp_q[0])) begin
        n_fail++;
        $display("FAIL dump_entry: vld=%b idx=%0d cnt=%0d, required 1 %0d %0d", d_out_valid, d_out_idx, d_out_cnt, k, exp_q[0]);
      end
      if (d_out_ready) begin
        void'(exp_q.pop_front());
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    d_out_ready = 0;
    d_start = 0;
    n_chk++;
    if (exp_q.size() != 0 || d_done !== 1 || d_busy !== 0 || d_out_valid !== 0) begin
      n_fail++;
      $display("FAIL dump_end: left=%0d done=%b busy=%b vld=%b, required 0 1 0 0", exp_q.size(), d_done, d_busy, d_out_valid);
    end
    exp_q.delete();
    @(negedge clk);
    n_chk++;
    if (d_done !== 0 || done_cnt !== dc + 1) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b pulses=%0d, required 0 %0d", d_done, done_cnt - dc, 1);
    end
  endtask

  task automatic test_single_value();
    run_default(0, 0, 0, 0);
  endtask

  task automatic test_random_stalls();
    run_default(1, 1, 1, 0);
  endtask

  task automatic test_start_ignored();
    run_default(1, 1, 1, 1);
  endtask

  task automatic test_boundary();
    int vals[6] = '{255, 256, 287, 288, 511, 512};
    int exp_b[10] = '{2, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    b_start = 1;
    @(negedge clk) b_start = 0;
    for (int i = 0; i < 6; i++) begin
      b_in_valid = 1;
      b_in_data = 16'(vals[i]);
      n_chk++;
      if (b_in_ready !== 1) begin
        n_fail++;
        $display("FAIL bnd_ready: sample %0d ready=%b, required 1", i, b_in_ready);
      end
      exp_q.push_back(exp_b[i]);
      @(negedge clk);
    end
    for (int i = 6; i < 10; i++) exp_q.push_back(exp_b[i]);
    b_in_valid = 0;
    n_chk++;
    if (b_in_ready !== 0 || b_min !== 16'd255 || b_max !== 16'd512 || b_sum !== 20'd2109) begin
      n_fail++;
      $display("FAIL bnd_stats: rdy=%b min=%0d max=%0d sum=%0d, required 0 255 512 2109", b_in_ready, b_min, b_max, b_sum);
    end
    b_out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      if (b_out_valid !== 1 || b_out_idx !== 4'(k) || b_out_cnt !== 16'(exp_q[0])) begin
        n_fail++;
        $display("FAIL bnd_entry: vld=%b idx=%0d cnt=%0d, required 1 %0d %0d", b_out_valid, b_out_idx, b_out_cnt, k, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    b_out_ready = 0;
    n_chk++;
    if (b_done !== 1 || b_busy !== 0) begin
      n_fail++;
      $display("FAIL bnd_done: done=%b busy=%b, required 1 0", b_done, b_busy);
    end
  endtask

  task automatic test_saturate();
    s_start = 1;
    @(negedge clk) s_start = 0;
    s_in_valid = 1;
    s_in_data = 16'd256;
    repeat (20) @(negedge clk);
    s_in_valid = 0;
    exp_q.push_back(15);
    for (int i = 1; i < 10; i++) exp_q.push_back(0);
    n_chk++;
    if (s_sum !== 22'd5120 || s_out_valid !== 1) begin
      n_fail++;
      $display("FAIL sat_stats: sum=%0d vld=%b, required 5120 1", s_sum, s_out_valid);
    end
    s_out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      if (s_out_idx !== 4'(k) || s_out_cnt !== 4'(exp_q[0])) begin
        n_fail++;
        $display("FAIL sat_entry: idx=%0d cnt=%0d, required %0d %0d", s_out_idx, s_out_cnt, k, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    s_out_ready = 0;
    n_chk++;
    if (s_done !== 1) begin
      n_fail++;
      $display("FAIL sat_done: done=%b, required 1", s_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_value();
    test_boundary();
    test_random_stalls();
    test_saturate();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
